// File: rtl/page_ram_reader_if.sv
// Signal bundle for page_ram_reader: RAM write port, stream command,
// status flags and the valid/ready byte stream.
interface page_ram_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Controller side: issues writes and commands, consumes the byte stream.
  modport master (
    output wr_en, wr_addr, wr_data, start, start_addr, length, out_ready,
    input  busy, done, out_valid, out_data
  );

  // Reader side: owns the RAM and produces the byte stream.
  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_addr, length, out_ready,
    output busy, done, out_valid, out_data
  );
endinterface

// File: rtl/page_ram_reader.sv
// Read-side engine for the page-table block RAM. Streams a wrapping address
// range out of the RAM at one byte per clock. The RAM's registered read port
// doubles as the primary output register; a single skid entry catches the one
// read that can already be in flight when the consumer stalls.
module page_ram_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic             hw_clk,
  input  logic             rst,
  page_ram_reader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rdLeft_q, rdLeft_d;
  logic [ADDR_W:0]   outLeft_q, outLeft_d;
  logic [DATA_W-1:0] ramData_q;
  logic              ramValid_q, ramValid_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
  logic              skidValid_q, skidValid_d;
  logic [ADDR_W:0]   lenClamped;
  logic              rdEn;
  logic              outValid;
  logic              pop;

  // The skid entry, when occupied, always holds the older byte, so it is the head.
  assign lenClamped    = (bus.length > DEPTH_CNT) ? DEPTH_CNT : bus.length;
  assign outValid      = skidValid_q | ramValid_q;
  assign pop           = outValid & bus.out_ready;
  assign rdEn          = (state_q == RUN) && (rdLeft_q != '0) && !skidValid_q;

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);
  assign bus.out_valid = outValid;
  assign bus.out_data  = skidValid_q ? skidData_q : ramData_q;

  // RAM write port: contents survive reset and writes ignore the stream state.
  always_ff @(posedge hw_clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered read port; a same-edge write to the same address yields old data.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      ramData_q <= '0;
    end else if (rdEn) begin
      ramData_q <= mem[addr_q];
    end
  end

  // Sequencer: latch the command, walk the address range, count handshakes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rdLeft_d  = rdLeft_q;
    outLeft_d = outLeft_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d    = bus.start_addr;
          rdLeft_d  = lenClamped;
          outLeft_d = lenClamped;
          state_d   = (lenClamped == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (rdEn) begin
          addr_d   = addr_q + 1'b1;
          rdLeft_d = rdLeft_q - 1'b1;
        end
        if (pop) begin
          outLeft_d = outLeft_q - 1'b1;
          if (outLeft_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output path: spill the unconsumed head into the skid when a new read lands on it.
  always_comb begin
    ramValid_d  = ramValid_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (skidValid_q) begin
      if (pop) begin
        skidValid_d = 1'b0;
      end
    end else if (rdEn && ramValid_q && !pop) begin
      skidValid_d = 1'b1;
      skidData_d  = ramData_q;
    end
    if (rdEn) begin
      ramValid_d = 1'b1;
    end else if (pop && !skidValid_q) begin
      ramValid_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any stream in progress.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rdLeft_q    <= '0;
      outLeft_q   <= '0;
      ramValid_q  <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rdLeft_q    <= rdLeft_d;
      outLeft_q   <= outLeft_d;
      ramValid_q  <= ramValid_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end
endmodule

// File: tb/tb_page_ram_reader.sv
// Bench for page_ram_reader: a plain array mirrors the RAM, and each stream is
// checked byte-by-byte against the address-ordered contents of that array.
module tb_page_ram_reader;
  logic hw_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] refMem [256];
  logic [7:0] gotQ [$];
  int         stallErrs;
  bit         doneSeen;

  page_ram_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  page_ram_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .hw_clk(hw_clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 hw_clk = ~hw_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected run to end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge hw_clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    refMem[a]   = d;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++) write_byte(8'(i), 8'(i) ^ 8'hA5);
  endtask

  task automatic do_start(input logic [7:0] a, input logic [8:0] len);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.length     = len;
    tick();
    bus.start      = 1'b0;
    bus.start_addr = 8'($urandom());
    bus.length     = 9'($urandom());
  endtask

  // Consume bytes with random readiness until done shows up or the budget runs out.
  task automatic collect(input int readyPct, input int limit);
    logic [7:0] prevData;
    bit         prevStall;
    prevData  = '0;
    prevStall = 1'b0;
    gotQ.delete();
    stallErrs = 0;
    doneSeen  = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (prevStall && (bus.out_valid !== 1'b1 || bus.out_data !== prevData)) stallErrs++;
      if (bus.done === 1'b1) begin
        doneSeen = 1'b1;
        break;
      end
      bus.out_ready = ($urandom_range(0, 99) < readyPct);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) gotQ.push_back(bus.out_data);
      prevStall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prevData  = bus.out_data;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", bus.out_data); end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b expected 0/0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_single_byte();
    write_byte(8'd3, 8'h0E);
    bus.out_ready = 1'b1;
    do_start(8'd3, 9'd1);
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_e0: got busy=%b valid=%b expected 1/0", bus.busy, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== refMem[3]) begin
      errors++; $display("[TB] FAIL single_data: got valid=%b data=%h expected 1/%h", bus.out_valid, bus.out_data, refMem[3]);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done: got done=%b valid=%b expected 1/0", bus.done, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_idle: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
    write_byte(8'd3, 8'h0F);
    do_start(8'd3, 9'd1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== refMem[3]) begin
      errors++; $display("[TB] FAIL single_rewrite: got valid=%b data=%h expected 1/%h", bus.out_valid, bus.out_data, refMem[3]);
    end
    tick();
    tick();
  endtask

  task automatic test_wrap();
    fill_pattern();
    bus.out_ready = 1'b1;
    do_start(8'hFE, 9'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== refMem[8'(8'hFE + k)]) begin
        errors++;
        $display("[TB] FAIL wrap_byte%0d: got valid=%b data=%h expected 1/%h", k, bus.out_valid, bus.out_data, refMem[8'(8'hFE + k)]);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_done: got done=%b valid=%b expected 1/0", bus.done, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_random_backpressure();
    logic [7:0] a;
    a = 8'h10;
    bus.out_ready = 1'b0;
    do_start(a, 9'd256);
    collect(50, 3000);
    checks++;
    if (doneSeen !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %b expected 1", doneSeen); end
    checks++;
    if (gotQ.size() !== 256) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 256", gotQ.size()); end
    for (int k = 0; k < gotQ.size() && k < 256; k++) begin
      checks++;
      if (gotQ[k] !== refMem[8'(a + k)]) begin
        errors++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", k, gotQ[k], refMem[8'(a + k)]);
      end
    end
    checks++;
    if (stallErrs !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stallErrs); end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_zero_length();
    do_start(8'($urandom()), 9'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_done: got done=%b busy=%b valid=%b expected 1/1/0", bus.done, bus.busy, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_idle: got done=%b busy=%b valid=%b expected 0/0/0", bus.done, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_start_while_busy();
    bus.out_ready = 1'b0;
    do_start(8'h30, 9'd8);
    tick();
    tick();
    bus.start      = 1'b1;
    bus.start_addr = 8'h40;
    bus.length     = 9'd3;
    tick();
    bus.start      = 1'b0;
    collect(100, 200);
    checks++;
    if (gotQ.size() !== 8 || doneSeen !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_start_len: got %0d bytes done=%b expected 8/1", gotQ.size(), doneSeen);
    end
    for (int k = 0; k < gotQ.size() && k < 8; k++) begin
      checks++;
      if (gotQ[k] !== refMem[8'(8'h30 + k)]) begin
        errors++; $display("[TB] FAIL busy_start_byte%0d: got %h expected %h", k, gotQ[k], refMem[8'(8'h30 + k)]);
      end
    end
    tick();
  endtask

  task automatic test_clamp();
    logic [7:0] a;
    a = 8'($urandom());
    do_start(a, 9'($urandom_range(257, 511)));
    collect(70, 3000);
    checks++;
    if (gotQ.size() !== 256 || doneSeen !== 1'b1) begin
      errors++; $display("[TB] FAIL clamp_len: got %0d bytes done=%b expected 256/1", gotQ.size(), doneSeen);
    end
    for (int k = 0; k < gotQ.size() && k < 256; k++) begin
      checks++;
      if (gotQ[k] !== refMem[8'(a + k)]) begin
        errors++; $display("[TB] FAIL clamp_byte%0d: got %h expected %h", k, gotQ[k], refMem[8'(a + k)]);
      end
    end
    checks++;
    if (stallErrs !== 0) begin errors++; $display("[TB] FAIL clamp_stable: got %0d unstable stalls expected 0", stallErrs); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [7:0] a;
    int cnt;
    a = 8'($urandom());
    cnt = 0;
    bus.out_ready = 1'b1;
    do_start(a, 9'd20);
    for (int g = 0; g < 100 && cnt < 5; g++) begin
      if (bus.out_valid === 1'b1) cnt++;
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_state: got valid=%b busy=%b done=%b expected 0/0/0", bus.out_valid, bus.busy, bus.done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_nodone: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
    do_start(a, 9'd20);
    collect(60, 500);
    checks++;
    if (gotQ.size() !== 20 || doneSeen !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_len: got %0d bytes done=%b expected 20/1", gotQ.size(), doneSeen);
    end
    for (int k = 0; k < gotQ.size() && k < 20; k++) begin
      checks++;
      if (gotQ[k] !== refMem[8'(a + k)]) begin
        errors++; $display("[TB] FAIL midrst_byte%0d: got %h expected %h", k, gotQ[k], refMem[8'(a + k)]);
      end
    end
    tick();
  endtask

  // Byte k of a stream starting at 0x75 is read at the (k+1)th edge after start.
  task automatic test_collision();
    logic [7:0] a;
    logic [7:0] expQ [$];
    a = 8'h75;
    for (int k = 0; k < 8; k++) expQ.push_back(refMem[8'(a + k)]);
    expQ[5] = 8'h3C;
    bus.out_ready = 1'b1;
    do_start(a, 9'd8);
    gotQ.delete();
    doneSeen = 1'b0;
    for (int p = 0; p < 40; p++) begin
      bus.wr_en = 1'b0;
      if (p == 2) begin bus.wr_en = 1'b1; bus.wr_addr = 8'h77; bus.wr_data = 8'h55; end
      if (p == 3) begin bus.wr_en = 1'b1; bus.wr_addr = 8'h7A; bus.wr_data = 8'h3C; end
      if (bus.done === 1'b1) begin
        doneSeen = 1'b1;
        break;
      end
      if (bus.out_valid === 1'b1) gotQ.push_back(bus.out_data);
      tick();
    end
    bus.wr_en = 1'b0;
    refMem[8'h77] = 8'h55;
    refMem[8'h7A] = 8'h3C;
    checks++;
    if (gotQ.size() !== 8 || doneSeen !== 1'b1) begin
      errors++; $display("[TB] FAIL coll_len: got %0d bytes done=%b expected 8/1", gotQ.size(), doneSeen);
    end
    for (int k = 0; k < gotQ.size() && k < 8; k++) begin
      checks++;
      if (gotQ[k] !== expQ[k]) begin
        errors++; $display("[TB] FAIL coll_byte%0d: got %h expected %h", k, gotQ[k], expQ[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got busy=%b expected 0", bus.busy); end
    do_start(8'h75, 9'd8);
    collect(100, 100);
    checks++;
    if (gotQ.size() !== 8 || doneSeen !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_len: got %0d bytes done=%b expected 8/1", gotQ.size(), doneSeen);
    end
    for (int k = 0; k < gotQ.size() && k < 8; k++) begin
      checks++;
      if (gotQ[k] !== refMem[8'(8'h75 + k)]) begin
        errors++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", k, gotQ[k], refMem[8'(8'h75 + k)]);
      end
    end
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single_byte();
    test_wrap();
    test_random_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_clamp();
    test_mid_reset();
    test_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
